// File: rtl/rct_pkg.sv
// rtl/rct_pkg.sv - shared types, widths and lane slice helpers for the forward RCT
//
// Purpose : chroma mode encoding, stage-1 width helpers and RGB component
//           extraction used by rct_lane and rct_forward_lanes.
// Ports   : none (package).
package rct_pkg;

  // Widest component the slice helpers can address.
  localparam int MAX_PIX_W = 16;

  typedef enum logic {
    MODE_444 = 1'b0,
    MODE_422 = 1'b1
  } mode_e;

  // R + 2G + B needs two guard bits above the component width.
  function automatic int sum_width(input int pix_w);
    return pix_w + 2;
  endfunction

  // Component differences need one extra (sign) bit.
  function automatic int chr_width(input int pix_w);
    return pix_w + 1;
  endfunction

  // Component idx (0=B, 1=G, 2=R) of a zero-extended lane word of
  // component width w.
  function automatic logic [MAX_PIX_W-1:0] comp_at(input logic [3*MAX_PIX_W-1:0] px,
                                                   input int w, input int idx);
    logic [MAX_PIX_W-1:0] mask;
    mask = (MAX_PIX_W'(1) << w) - MAX_PIX_W'(1);
    return MAX_PIX_W'(px >> (idx * w)) & mask;
  endfunction

  function automatic logic [MAX_PIX_W-1:0] get_r(input logic [3*MAX_PIX_W-1:0] px, input int w);
    return comp_at(px, w, 2);
  endfunction

  function automatic logic [MAX_PIX_W-1:0] get_g(input logic [3*MAX_PIX_W-1:0] px, input int w);
    return comp_at(px, w, 1);
  endfunction

  function automatic logic [MAX_PIX_W-1:0] get_b(input logic [3*MAX_PIX_W-1:0] px, input int w);
    return comp_at(px, w, 0);
  endfunction

endpackage

// File: rtl/rct_lane.sv
// rtl/rct_lane.sv - one-lane stage-1 RCT arithmetic (sum, cb, cr)
//
// Purpose : combinational R+2G+B, B-G and R-G for a single pixel.
// Ports   : rgb_i  in  3*IMG_PIX_W     {R, G, B}, B in the low bits
//           sum_o  out IMG_PIX_W+2     R + 2G + B (unsigned)
//           cb_o   out IMG_PIX_W+1     B - G (two's complement)
//           cr_o   out IMG_PIX_W+1     R - G (two's complement)
module rct_lane
  import rct_pkg::*;
#(
  parameter int IMG_PIX_W = 8
) (
  input  logic [3*IMG_PIX_W-1:0] rgb_i,
  output logic [IMG_PIX_W+1:0]   sum_o,
  output logic [IMG_PIX_W:0]     cb_o,
  output logic [IMG_PIX_W:0]     cr_o
);

  localparam int W     = IMG_PIX_W;
  localparam int SUM_W = sum_width(W);
  localparam int CHR_W = chr_width(W);

  if (IMG_PIX_W < 1 || IMG_PIX_W > MAX_PIX_W) begin : g_pix_w_check
    $error("rct_lane: IMG_PIX_W out of range");
  end

  logic [3*MAX_PIX_W-1:0] px;
  logic [W-1:0]           r;
  logic [W-1:0]           g;
  logic [W-1:0]           b;

  assign px = (3*MAX_PIX_W)'(rgb_i);
  assign r  = W'(get_r(px, W));
  assign g  = W'(get_g(px, W));
  assign b  = W'(get_b(px, W));

  assign sum_o = SUM_W'(r) + (SUM_W'(g) << 1) + SUM_W'(b);
  assign cb_o  = CHR_W'(b) - CHR_W'(g);
  assign cr_o  = CHR_W'(r) - CHR_W'(g);

endmodule

// File: rtl/rct_forward_lanes.sv
// rtl/rct_forward_lanes.sv - multi-lane forward reversible colour transform with backpressure
//
// Purpose : two-stage valid/ready pipeline computing JPEG2000 RCT luma/chroma
//           for LANES pixels per beat, optional 4:2:2 chroma pair averaging,
//           SOF/EOL sideband and a completed-line counter.
// Config  : RCT_DC_SHIFT_EN - when defined, luma is DC level shifted by
//           -2^(IMG_PIX_W-1) and emitted as a signed value.
// Ports   : HCLK, HRESETn            clock, async active-low reset
//           s_valid/s_ready          input handshake
//           s_sof/s_eol/s_rgb        input beat (lane i {R,G,B} at 3*i*IMG_PIX_W)
//           mode_422                 chroma mode, sampled on accepted SOF beat
//           m_valid/m_ready          output handshake
//           m_sof/m_eol              sideband delayed with data
//           m_y/m_cb/m_cr            per-lane samples, WAVE_PIX_W each
//           lines_done               lines emitted since last output SOF
module rct_forward_lanes
  import rct_pkg::*;
#(
  parameter int IMG_PIX_W  = 8,
  parameter int WAVE_PIX_W = 10,
  parameter int LANES      = 2
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          s_sof,
  input  logic                          s_eol,
  input  logic [LANES*3*IMG_PIX_W-1:0]  s_rgb,
  input  logic                          mode_422,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic [LANES*WAVE_PIX_W-1:0]   m_y,
  output logic [LANES*WAVE_PIX_W-1:0]   m_cb,
  output logic [LANES*WAVE_PIX_W-1:0]   m_cr,
  output logic [15:0]                   lines_done
);

  localparam int SUM_W = sum_width(IMG_PIX_W);
  localparam int CHR_W = chr_width(IMG_PIX_W);
  localparam int OW    = WAVE_PIX_W;

  if (WAVE_PIX_W < IMG_PIX_W + 1) begin : g_wave_w_check
    $error("rct_forward_lanes: WAVE_PIX_W must be >= IMG_PIX_W+1");
  end

  // Handshake
  logic en1, en2, s_fire, m_fire;
  logic v1_q, v2_q;

  assign en2     = !v2_q || m_ready;
  assign en1     = !v1_q || en2;
  assign s_ready = en1;
  assign s_fire  = s_valid && en1;
  assign m_fire  = v2_q && m_ready;

  // Frame mode: an SOF beat carries its own requested mode.
  mode_e mode_q, beat_mode;
  assign beat_mode = s_sof ? mode_e'(mode_422) : mode_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mode_q <= MODE_444;
    end else if (s_fire && s_sof) begin
      mode_q <= mode_e'(mode_422);
    end
  end

  // Stage 1
  logic [LANES*SUM_W-1:0] sum_w, sum1_q;
  logic [LANES*CHR_W-1:0] cb_w, cr_w, cb1_q, cr1_q;
  logic                   sof1_q, eol1_q;
  mode_e                  mode1_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rct_lane #(
      .IMG_PIX_W(IMG_PIX_W)
    ) u_lane (
      .rgb_i(s_rgb[i*3*IMG_PIX_W +: 3*IMG_PIX_W]),
      .sum_o(sum_w[i*SUM_W +: SUM_W]),
      .cb_o (cb_w[i*CHR_W +: CHR_W]),
      .cr_o (cr_w[i*CHR_W +: CHR_W])
    );
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      v1_q    <= 1'b0;
      sof1_q  <= 1'b0;
      eol1_q  <= 1'b0;
      mode1_q <= MODE_444;
      sum1_q  <= '0;
      cb1_q   <= '0;
      cr1_q   <= '0;
    end else if (en1) begin
      v1_q <= s_valid;
      if (s_valid) begin
        sof1_q  <= s_sof;
        eol1_q  <= s_eol;
        mode1_q <= beat_mode;
        sum1_q  <= sum_w;
        cb1_q   <= cb_w;
        cr1_q   <= cr_w;
      end
    end
  end

  // Stage 2 next-state, per lane
  logic [LANES*OW-1:0] y2_d, cb2_d, cr2_d;
  logic [LANES*OW-1:0] y2_q, cb2_q, cr2_q;
  logic                sof2_q, eol2_q;

  for (genvar i = 0; i < LANES; i++) begin : g_out
    logic        [SUM_W-1:0] sum_l;
    logic signed [CHR_W-1:0] cb_l, cr_l;
    logic        [OW-1:0]    cb_444, cr_444, cb_422, cr_422;

    assign sum_l  = sum1_q[i*SUM_W +: SUM_W];
    assign cb_l   = cb1_q[i*CHR_W +: CHR_W];
    assign cr_l   = cr1_q[i*CHR_W +: CHR_W];
    assign cb_444 = OW'(cb_l);
    assign cr_444 = OW'(cr_l);

`ifdef RCT_DC_SHIFT_EN
    assign y2_d[i*OW +: OW] = OW'(sum_l >> 2) - OW'(1 << (IMG_PIX_W - 1));
`else
    assign y2_d[i*OW +: OW] = OW'(sum_l >> 2);
`endif

    if ((i ^ 1) < LANES) begin : g_pair
      // Both lanes of a pair compute the same symmetric sum.
      localparam int P = i ^ 1;
      logic signed [CHR_W-1:0] cb_p, cr_p;
      logic signed [CHR_W:0]   cb_s, cr_s;

      assign cb_p   = cb1_q[P*CHR_W +: CHR_W];
      assign cr_p   = cr1_q[P*CHR_W +: CHR_W];
      assign cb_s   = (CHR_W+1)'(cb_l) + (CHR_W+1)'(cb_p);
      assign cr_s   = (CHR_W+1)'(cr_l) + (CHR_W+1)'(cr_p);
      assign cb_422 = OW'(cb_s >>> 1);
      assign cr_422 = OW'(cr_s >>> 1);
    end else begin : g_solo
      // Unpaired odd last lane keeps its own chroma.
      assign cb_422 = cb_444;
      assign cr_422 = cr_444;
    end

    assign cb2_d[i*OW +: OW] = (mode1_q == MODE_422) ? cb_422 : cb_444;
    assign cr2_d[i*OW +: OW] = (mode1_q == MODE_422) ? cr_422 : cr_444;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      v2_q   <= 1'b0;
      sof2_q <= 1'b0;
      eol2_q <= 1'b0;
      y2_q   <= '0;
      cb2_q  <= '0;
      cr2_q  <= '0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sof2_q <= sof1_q;
        eol2_q <= eol1_q;
        y2_q   <= y2_d;
        cb2_q  <= cb2_d;
        cr2_q  <= cr2_d;
      end
    end
  end

  // Completed-line counter, advanced on output handshakes only.
  logic [15:0] lines_q, lines_d;

  always_comb begin
    lines_d = lines_q;
    if (m_fire) begin
      if (sof2_q && eol2_q) begin
        lines_d = 16'd1;
      end else if (sof2_q) begin
        lines_d = 16'd0;
      end else if (eol2_q && (lines_q != 16'hFFFF)) begin
        lines_d = lines_q + 16'd1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lines_q <= 16'd0;
    end else begin
      lines_q <= lines_d;
    end
  end

  assign m_valid    = v2_q;
  assign m_sof      = sof2_q;
  assign m_eol      = eol2_q;
  assign m_y        = y2_q;
  assign m_cb       = cb2_q;
  assign m_cr       = cr2_q;
  assign lines_done = lines_q;

endmodule

// File: tb/tb_rct_forward_lanes.sv
// tb/tb_rct_forward_lanes.sv - self-checking bench for rct_forward_lanes
module tb_rct_forward_lanes;

  localparam int W  = 8;
  localparam int WW = 10;
  localparam int L  = 2;
`ifdef RCT_DC_SHIFT_EN
  localparam int DC = 128;
`else
  localparam int DC = 0;
`endif

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic             s_valid, s_ready, s_sof, s_eol, mode_422;
  logic [L*3*W-1:0] s_rgb;
  logic             m_valid, m_ready, m_sof, m_eol;
  logic [L*WW-1:0]  m_y, m_cb, m_cr;
  logic [15:0]      lines_done;

  always #5 HCLK = ~HCLK;

  rct_forward_lanes #(
    .IMG_PIX_W (W),
    .WAVE_PIX_W(WW),
    .LANES     (L)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sof     (s_sof),
    .s_eol     (s_eol),
    .s_rgb     (s_rgb),
    .mode_422  (mode_422),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_sof     (m_sof),
    .m_eol     (m_eol),
    .m_y       (m_y),
    .m_cb      (m_cb),
    .m_cr      (m_cr),
    .lines_done(lines_done)
  );

  typedef struct {
    logic [L*WW-1:0] y, cb, cr;
    logic            sof, eol;
  } beat_t;

  typedef struct {
    logic [L*3*W-1:0] rgb;
    logic             sof, md;
    logic [L*WW-1:0]  y, cb, cr;
  } vec_t;

  beat_t exp_q[$];
  beat_t out_b;
  vec_t  tbl[5];
  int    n_chk, n_fail, ld_m, acc_cnt;
  logic  mode_m, out_seen, last_acc;

  function automatic int floor_half(input int s);
    return (s < 0 && (s % 2) != 0) ? (s / 2 - 1) : (s / 2);
  endfunction

  function automatic logic [L*3*W-1:0] mk(input int r0, g0, b0, r1, g1, b1);
    return {W'(r1), W'(g1), W'(b1), W'(r0), W'(g0), W'(b0)};
  endfunction

  function automatic logic [L*WW-1:0] pk(input int a0, a1);
    return {WW'(a1), WW'(a0)};
  endfunction

  // Reference: transform from the colour rules with integer arithmetic.
  function automatic beat_t model(input logic [L*3*W-1:0] rgb, input logic sof, eol, md);
    int    r, g, b, a;
    int    cb[L], cr[L];
    beat_t e;
    for (int i = 0; i < L; i++) begin
      r = int'(rgb[(3*i+2)*W +: W]);
      g = int'(rgb[(3*i+1)*W +: W]);
      b = int'(rgb[(3*i)*W +: W]);
      e.y[i*WW +: WW] = WW'((r + 2*g + b) / 4 - DC);
      cb[i] = b - g;
      cr[i] = r - g;
    end
    if (md) begin
      for (int k = 0; k + 1 < L; k += 2) begin
        a = floor_half(cb[k] + cb[k+1]); cb[k] = a; cb[k+1] = a;
        a = floor_half(cr[k] + cr[k+1]); cr[k] = a; cr[k+1] = a;
      end
    end
    for (int i = 0; i < L; i++) begin
      e.cb[i*WW +: WW] = WW'(cb[i]);
      e.cr[i*WW +: WW] = WW'(cr[i]);
    end
    e.sof = sof;
    e.eol = eol;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: sample #1 after the driving negedge, settle handshakes in
  // the model, then move on to the next negedge.
  task automatic step();
    beat_t e;
    #1;
    chk("lines_done", 64'(lines_done), 64'(ld_m));
    out_seen = 1'b0;
    last_acc = 1'b0;
    if (HRESETn && s_valid && s_ready) begin
      if (s_sof) mode_m = mode_422;
      exp_q.push_back(model(s_rgb, s_sof, s_eol, mode_m));
      acc_cnt++;
      last_acc = 1'b1;
    end
    if (HRESETn && m_valid && m_ready) begin
      out_seen = 1'b1;
      out_b.y = m_y; out_b.cb = m_cb; out_b.cr = m_cr;
      out_b.sof = m_sof; out_b.eol = m_eol;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("beat", 64'({m_sof, m_eol, m_y, m_cb, m_cr}),
            64'({e.sof, e.eol, e.y, e.cb, e.cr}));
      end
      if (m_sof && m_eol)  ld_m = 1;
      else if (m_sof)      ld_m = 0;
      else if (m_eol)      ld_m = (ld_m == 65535) ? 65535 : ld_m + 1;
    end
    @(negedge HCLK);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  // Offer one beat for a single cycle, then drain a few idle cycles.
  task automatic send(input logic sof, eol, md, input logic [L*3*W-1:0] rgb);
    s_valid = 1'b1; s_sof = sof; s_eol = eol; mode_422 = md; s_rgb = rgb;
    step();
    idle();
    for (int k = 0; k < 4; k++) step();
  endtask

  initial begin
    int   n0, lat;
    logic seen;
    n_chk = 0; n_fail = 0; ld_m = 0; acc_cnt = 0; mode_m = 1'b0;
    out_seen = 1'b0; last_acc = 1'b0;
    HRESETn = 1'b0; m_ready = 1'b1; mode_422 = 1'b0; s_rgb = '0;
    idle();

    tbl[0] = '{mk(255,255,255,255,255,255), 1'b1, 1'b0, pk(255-DC,255-DC), pk(0,0),       pk(0,0)};
    tbl[1] = '{mk(0,255,0,0,255,0),         1'b0, 1'b0, pk(127-DC,127-DC), pk(-255,-255), pk(-255,-255)};
    tbl[2] = '{mk(10,0,20,0,0,0),           1'b1, 1'b1, pk(7-DC,0-DC),     pk(10,10),     pk(5,5)};
    tbl[3] = '{mk(0,3,0,0,4,0),             1'b0, 1'b0, pk(1-DC,2-DC),     pk(-4,-4),     pk(-4,-4)};
    tbl[4] = '{mk(1,2,3,200,100,50),        1'b1, 1'b0, pk(2-DC,112-DC),   pk(1,-50),     pk(-1,100)};

    // Reset state
    @(negedge HCLK);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_sof_eol", 64'({m_sof, m_eol}), 64'(0));
    chk("rst_m_data", 64'({m_y, m_cb, m_cr}), 64'(0));
    chk("rst_lines", 64'(lines_done), 64'(0));
    @(negedge HCLK);
    HRESETn = 1'b1;
    step(); step();

    // Directed vectors
    for (int t = 0; t < 5; t++) begin
      s_valid = 1'b1; s_sof = tbl[t].sof; s_eol = 1'b0;
      mode_422 = tbl[t].md; s_rgb = tbl[t].rgb;
      n0 = acc_cnt;
      step();
      chk("vec_accept", 64'(acc_cnt), 64'(n0 + 1));
      idle();
      seen = 1'b0; lat = 0;
      for (int k = 1; k <= 20 && !seen; k++) begin
        step();
        if (out_seen) begin seen = 1'b1; lat = k; end
      end
      chk("vec_seen", 64'(seen), 64'(1));
      chk("vec_y",  64'(out_b.y),  64'(tbl[t].y));
      chk("vec_cb", 64'(out_b.cb), 64'(tbl[t].cb));
      chk("vec_cr", 64'(out_b.cr), 64'(tbl[t].cr));
      if (t == 0) chk("latency", 64'(lat), 64'(2));
    end

    // Backpressure: only two beats fit while the sink stalls.
    m_ready = 1'b0; s_valid = 1'b1; s_sof = 1'b0; s_eol = 1'b0; mode_422 = 1'b0;
    s_rgb = 48'({$urandom(), $urandom()});
    n0 = acc_cnt;
    for (int k = 0; k < 5; k++) begin
      step();
      if (last_acc) s_rgb = 48'({$urandom(), $urandom()});
    end
    chk("stall_accepts", 64'(acc_cnt - n0), 64'(2));
    #1;
    chk("stall_s_ready", 64'(s_ready), 64'(0));
    idle(); m_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("stall_drain", 64'(exp_q.size()), 64'(0));

    // Line counting
    send(1'b1, 1'b0, 1'b0, mk(1,1,1,1,1,1)); chk("lines_sof", 64'(lines_done), 64'(0));
    send(1'b0, 1'b1, 1'b0, mk(2,2,2,2,2,2)); chk("lines_1",   64'(lines_done), 64'(1));
    send(1'b0, 1'b1, 1'b0, mk(3,3,3,3,3,3)); chk("lines_2",   64'(lines_done), 64'(2));
    send(1'b0, 1'b1, 1'b0, mk(4,4,4,4,4,4)); chk("lines_3",   64'(lines_done), 64'(3));
    send(1'b1, 1'b1, 1'b0, mk(5,5,5,5,5,5)); chk("lines_sofeol", 64'(lines_done), 64'(1));

    // Reset in mid-frame with output held
    send(1'b1, 1'b1, 1'b1, mk(9,8,7,6,5,4));
    send(1'b0, 1'b1, 1'b0, mk(1,2,3,4,5,6));
    m_ready = 1'b0;
    s_valid = 1'b1; s_rgb = mk(50,60,70,80,90,100); step();
    s_rgb = mk(7,7,7,9,9,9); step();
    idle(); step();
    #1;
    chk("pre_rst_valid", 64'(m_valid), 64'(1));
    HRESETn = 1'b0;
    exp_q.delete(); ld_m = 0; mode_m = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'(0));
    chk("mid_rst_lines", 64'(lines_done), 64'(0));
    chk("mid_rst_mode", 64'(dut.mode_q), 64'(0));
    @(negedge HCLK);
    step();
    HRESETn = 1'b1; m_ready = 1'b1;
    step();
    s_valid = 1'b1; s_rgb = mk(0,0,20,0,0,0); mode_422 = 1'b1;
    step();
    idle();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (out_seen) seen = 1'b1;
    end
    chk("restart_seen", 64'(seen), 64'(1));
    chk("restart_cb_444", 64'(out_b.cb), 64'(pk(20, 0)));
    send(1'b0, 1'b1, 1'b0, mk(1,1,1,1,1,1));
    chk("restart_lines", 64'(lines_done), 64'(1));

    // Randomized traffic against the reference model
    idle();
    for (int k = 0; k < 500; k++) begin
      if (!s_valid || last_acc) begin
        s_valid  = ($urandom_range(3) != 0);
        s_sof    = ($urandom_range(15) == 0);
        s_eol    = ($urandom_range(3) == 0);
        mode_422 = $urandom_range(1) == 1;
        s_rgb    = 48'({$urandom(), $urandom()});
      end
      m_ready = ($urandom_range(2) != 0);
      step();
    end
    idle(); m_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("random_drain", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
